flag_fwd_unit: RTL and testbench

- Owns the architectural carry/zero flags (C, Z) and supplies forwarded flag values to the ID-stage branch-condition check.
- That check consumes c_out/z_out for opcodes 10100..10111: BrZ, BrNZ, BrC and BrNC respectively.
- Flag results are produced by ALU ops in EX, carried through a shadow pipeline of COMMIT_STAGES slots, and committed to the architectural register on leaving the last slot.
- Generates a one-cycle stall when a branch in ID depends on a flag result still being computed in EX.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/flag_fwd_unit_if.sv | 22 ++
 rtl/flag_slot.sv | 15 +
 rtl/flag_fwd_unit.sv | 45 ++++
 tb/tb_flag_fwd_unit.sv | 122 ++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants and flag-slot type for the CPU pipeline
package cpu_pkg;
    localparam int OPC_W = 5;
    localparam logic [2:0] BR_CLASS = 3'b101;
    localparam logic [OPC_W-1:0] BR_Z  = 5'b10100;
    localparam logic [OPC_W-1:0] BR_NZ = 5'b10101;
    localparam logic [OPC_W-1:0] BR_C  = 5'b10110;
    localparam logic [OPC_W-1:0] BR_NC = 5'b10111;
    typedef struct packed {
        logic v;
        logic c;
        logic z;
    } flag_slot_t;
endpackage

// File: rtl/flag_fwd_unit_if.sv
// flag_fwd_unit_if: ID/EX flag signals exchanged between the pipeline and the flag forwarding unit
interface flag_fwd_unit_if #(parameter int OPC_W = cpu_pkg::OPC_W);
    logic [OPC_W-1:0] id_opcode;
    logic id_valid;
    logic ex_flag_we;
    logic ex_c;
    logic ex_z;
    logic pipe_hold;
    logic c_out;
    logic z_out;
    logic flag_stall;
    logic arch_c;
    logic arch_z;
    modport master (
        output id_opcode, id_valid, ex_flag_we, ex_c, ex_z, pipe_hold,
        input  c_out, z_out, flag_stall, arch_c, arch_z
    );
    modport slave (
        input  id_opcode, id_valid, ex_flag_we, ex_c, ex_z, pipe_hold,
        output c_out, z_out, flag_stall, arch_c, arch_z
    );
endinterface

// File: rtl/flag_slot.sv
// flag_slot: one shadow-pipeline flag register with freeze and sync reset
module flag_slot
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  flag_slot_t d,
    output flag_slot_t q
);
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (!hold) q <= d;
    end
endmodule

// File: rtl/flag_fwd_unit.sv
// flag_fwd_unit: architectural C/Z flags, shadow commit pipeline and youngest-first forwarding
// to the ID-stage branch check, plus the one-cycle EX-to-ID flag stall.
module flag_fwd_unit
    import cpu_pkg::*;
#(
    parameter int COMMIT_STAGES = 2
) (
    input logic clk,
    input logic rst,
    flag_fwd_unit_if.slave bus
);
    flag_slot_t [COMMIT_STAGES:0] slot;
    logic id_br;
    assign slot[0] = {bus.ex_flag_we, bus.ex_c, bus.ex_z};
    for (genvar g = 1; g <= COMMIT_STAGES; g++) begin : g_slot
        flag_slot u_slot (
            .clk (clk),
            .rst (rst),
            .hold(bus.pipe_hold),
            .d   (slot[g-1]),
            .q   (slot[g])
        );
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.arch_c <= 1'b0;
            bus.arch_z <= 1'b0;
        end else if (!bus.pipe_hold && slot[COMMIT_STAGES].v) begin
            bus.arch_c <= slot[COMMIT_STAGES].c;
            bus.arch_z <= slot[COMMIT_STAGES].z;
        end
    end
    // Walk oldest to youngest so the youngest valid slot overrides.
    always_comb begin
        bus.c_out = bus.arch_c;
        bus.z_out = bus.arch_z;
        for (int i = COMMIT_STAGES; i >= 1; i--) begin
            bus.c_out = slot[i].v ? slot[i].c : bus.c_out;
            bus.z_out = slot[i].v ? slot[i].z : bus.z_out;
        end
    end
    assign id_br = bus.id_valid && (bus.id_opcode[4:2] == BR_CLASS);
    // No EX-to-ID bypass: a branch behind a flag producer waits one cycle.
    assign bus.flag_stall = id_br && bus.ex_flag_we && !bus.pipe_hold;
endmodule

// File: tb/tb_flag_fwd_unit.sv
// tb_flag_fwd_unit: directed vectors with hand-computed expectations for flag_fwd_unit
module tb_flag_fwd_unit;
    logic clk = 1'b0;
    logic rst;
    int n_checks = 0;
    int n_fail = 0;
    flag_fwd_unit_if bus ();
    flag_fwd_unit #(.COMMIT_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic ex(input logic we, input logic c, input logic z);
        bus.ex_flag_we = we;
        bus.ex_c = c;
        bus.ex_z = z;
    endtask
    task automatic flags(input string tag, input logic c, input logic z, input logic ac, input logic az);
        #1;
        check({tag, ".c_out"}, bus.c_out, c);
        check({tag, ".z_out"}, bus.z_out, z);
        check({tag, ".arch_c"}, bus.arch_c, ac);
        check({tag, ".arch_z"}, bus.arch_z, az);
    endtask
    initial begin
        rst = 1'b1;
        bus.id_opcode = '0;
        bus.id_valid = 1'b0;
        bus.pipe_hold = 1'b0;
        ex(1'b1, 1'b1, 1'b1);
        step();
        step();
        rst = 1'b0;
        ex(1'b0, 1'b0, 1'b0);
        flags("reset", 0, 0, 0, 0);
        check("reset.stall", bus.flag_stall, 1'b0);
        // producer C=1,Z=0 in EX while BrC sits in ID
        ex(1'b1, 1'b1, 1'b0);
        bus.id_opcode = 5'b10110;
        bus.id_valid = 1'b1;
        #1 check("haz.stall", bus.flag_stall, 1'b1);
        step();
        ex(1'b0, 1'b0, 1'b0);
        #1 check("haz.stall_after", bus.flag_stall, 1'b0);
        flags("haz.slot1", 1, 0, 0, 0);
        step();
        flags("haz.slot2", 1, 0, 0, 0);
        step();
        flags("haz.commit", 1, 0, 1, 0);
        bus.id_valid = 1'b0;
        // back-to-back producers {1,1} then {0,0}
        ex(1'b1, 1'b1, 1'b1);
        step();
        ex(1'b1, 1'b0, 1'b0);
        step();
        ex(1'b0, 1'b0, 1'b0);
        flags("young.fwd", 0, 0, 1, 0);
        step();
        flags("young.commit1", 0, 0, 1, 1);
        step();
        flags("young.commit2", 0, 0, 0, 0);
        // producer {0,1} then freeze with a live producer pending in EX
        ex(1'b1, 1'b0, 1'b1);
        step();
        bus.pipe_hold = 1'b1;
        ex(1'b1, 1'b1, 1'b0);
        bus.id_opcode = 5'b10100;
        bus.id_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold.stall", bus.flag_stall, 1'b0);
            flags("hold", 0, 1, 0, 0);
            step();
        end
        flags("hold.end", 0, 1, 0, 0);
        bus.pipe_hold = 1'b0;
        bus.id_valid = 1'b0;
        ex(1'b0, 1'b0, 1'b0);
        step();
        flags("release.slot2", 0, 1, 0, 0);
        step();
        flags("release.commit", 0, 1, 0, 1);
        // stall decode corners
        ex(1'b1, 1'b1, 1'b1);
        bus.id_opcode = 5'b00011;
        bus.id_valid = 1'b1;
        #1 check("nonbr.stall", bus.flag_stall, 1'b0);
        bus.id_opcode = 5'b10100;
        bus.id_valid = 1'b0;
        #1 check("bubble.stall", bus.flag_stall, 1'b0);
        bus.id_opcode = 5'b10111;
        bus.id_valid = 1'b1;
        #1 check("brnc.stall", bus.flag_stall, 1'b1);
        bus.id_opcode = 5'b11000;
        #1 check("cls110.stall", bus.flag_stall, 1'b0);
        bus.id_valid = 1'b0;
        // reset with {1,1} in flight
        step();
        ex(1'b0, 1'b0, 1'b0);
        flags("rstmid.pre", 1, 1, 0, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        flags("rstmid.post", 0, 0, 0, 0);
        step();
        step();
        flags("rstmid.nocommit", 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
